// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a handshaked data bus, wait timeout and MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned accesses into a trap instead of aligning them.
module mem_stage #(
    parameter int DW  = 32,
    parameter int RW  = 5,
    parameter int WBW = 2,
    parameter int TMO = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DW-1:0]     i_result,
    input  logic [DW-1:0]     i_branch_pc,
    input  logic [DW-1:0]     i_read_data2,
    input  logic              i_zero,
    input  logic              i_branch,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic              i_unsigned,
    input  logic [1:0]        i_size,
    input  logic [RW-1:0]     i_write_reg,
    input  logic [WBW-1:0]    i_WB_control,
    output logic              o_dm_req,
    output logic              o_dm_we,
    output logic [DW/8-1:0]   o_dm_be,
    output logic [DW-1:0]     o_dm_addr,
    output logic [DW-1:0]     o_dm_wdata,
    input  logic              i_dm_ack,
    input  logic [DW-1:0]     i_dm_rdata,
    output logic              o_stall,
    output logic              o_branch,
    output logic [DW-1:0]     o_branch_pc,
    output logic [DW-1:0]     to_exmux,
    output logic [RW-1:0]     to_fu_ds,
    output logic              o_valid,
    output logic              o_bus_err,
    output logic              o_misalign,
    output logic [RW-1:0]     o_write_reg,
    output logic [DW-1:0]     o_write_data,
    output logic [DW-1:0]     o_result,
    output logic [WBW-1:0]    o_WB_control
);
    localparam int BW = DW / 8;
    localparam int OW = $clog2(BW);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [15:0]   cnt;
    logic [1:0]    sz;
    logic [OW-1:0] amask;
    logic [OW-1:0] aoff;
    logic [OW-1:0] roff;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] shifted;
    logic [DW-1:0] lmask;
    logic [DW-1:0] ldata;
    logic          mop;
    logic          trap;
    logic          go;
    logic          ack;
    logic          tmo;
    logic          sgn;

    assign o_branch    = i_valid & i_branch & i_zero;
    assign o_branch_pc = i_branch_pc;
    assign to_exmux    = i_result;
    assign to_fu_ds    = i_write_reg;

    assign mop   = i_valid & (i_mem_read | i_mem_write);
    assign sz    = (DW == 32 && i_size == 2'b11) ? 2'b10 : i_size;
    assign amask = OW'((32'd1 << sz) - 32'd1);
    assign aoff  = i_result[OW-1:0] & ~amask;
    assign be    = BW'(((32'd1 << (32'd1 << sz)) - 32'd1) << aoff);
    assign wdata = sz == 2'b00 ? {BW{i_read_data2[7:0]}} :
                   sz == 2'b01 ? {(BW/2){i_read_data2[15:0]}} :
                   sz == 2'b10 ? {(BW/4){i_read_data2[31:0]}} : i_read_data2;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (state == IDLE) & mop & (|(i_result[OW-1:0] & amask));
`else
    assign trap = 1'b0;
`endif

    assign go      = (state == IDLE) & mop & ~trap;
    assign ack     = (state == BUSY) & i_dm_ack;
    assign tmo     = (state == BUSY) & ~i_dm_ack & (cnt == 16'(TMO - 1));
    assign o_stall = go | ((state == BUSY) & ~i_dm_ack & ~tmo);

    // Load path: the request's own lane offset picks the data, the EX/MEM slot is held so size/sign are stable.
    assign roff    = o_dm_addr[OW-1:0];
    assign shifted = i_dm_rdata >> {roff, 3'b000};
    assign lmask   = {DW{1'b1}} >> (DW - (8 << sz));
    assign sgn     = ~i_unsigned & (|(shifted & lmask & ~(lmask >> 1)));
    assign ldata   = (shifted & lmask) | ({DW{sgn}} & ~lmask);

    // Bus FSM: latch the request on entry to BUSY and hold it until ack or timeout.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            o_dm_req   <= 1'b0;
            o_dm_we    <= 1'b0;
            o_dm_be    <= '0;
            o_dm_addr  <= '0;
            o_dm_wdata <= '0;
        end else if (go) begin
            state      <= BUSY;
            cnt        <= '0;
            o_dm_req   <= 1'b1;
            o_dm_we    <= i_mem_write;
            o_dm_be    <= be;
            o_dm_addr  <= {i_result[DW-1:OW], aoff};
            o_dm_wdata <= wdata;
        end else if (ack | tmo) begin
            state    <= IDLE;
            o_dm_req <= 1'b0;
        end else if (state == BUSY) begin
            cnt <= cnt + 16'd1;
        end
    end

    // MEM/WB register: bubble while stalled, otherwise retire the slot with load data or error status.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n || o_stall) begin
            o_valid      <= 1'b0;
            o_bus_err    <= 1'b0;
            o_misalign   <= 1'b0;
            o_write_reg  <= '0;
            o_write_data <= '0;
            o_result     <= '0;
            o_WB_control <= '0;
        end else begin
            o_valid      <= i_valid;
            o_bus_err    <= tmo;
            o_misalign   <= trap;
            o_write_reg  <= i_write_reg;
            o_write_data <= (ack & ~o_dm_we) ? ldata : '0;
            o_result     <= i_result;
            o_WB_control <= (tmo | trap) ? '0 : i_WB_control;
        end
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DW, 32, data/address width; legal values 32 or 64; byte-enable width is DW/8.
REQ-002 Parameter: RW, 5, register-index width.
REQ-003 Parameter: WBW, 2, WB control width.
REQ-004 Parameter: TMO, 255, maximum bus wait cycles before abort; legal range 1..65535.
REQ-005 Clock and reset: one clock, i_clk; reset i_rst_n is asynchronous and active-low.
REQ-006 i_clk  input  1  clock.
REQ-007 i_rst_n  input  1  asynchronous active-low reset.
REQ-008 i_valid  input  1  EX/MEM slot holds a live instruction.
REQ-009 i_result, i_branch_pc, i_read_data2  input  DW each  ALU result/address, branch target, store data.
REQ-010 i_zero, i_branch, i_mem_read, i_mem_write, i_unsigned  input  1 each  ALU zero, branch op, load op, store op, zero-extend load.
REQ-011 i_size  input  2  access size: 00 byte, 01 half, 10 word, 11 dword (DW=64 only; treated as word when DW=32).
REQ-012 i_write_reg  input  RW  destination register; i_WB_control  input  WBW  WB controls.
REQ-013 o_dm_req, o_dm_we  output  1 each  bus request, write strobe; o_dm_be  output  DW/8  byte enables.
REQ-014 o_dm_addr, o_dm_wdata  output  DW each  bus address, lane-aligned store data; i_dm_ack  input  1; i_dm_rdata  input  DW.
REQ-015 o_stall  output  1  hold EX/MEM and upstream stages.
REQ-016 o_branch  output  1  taken branch; o_branch_pc  output  DW  branch target.
REQ-017 to_exmux  output  DW  forwarded i_result; to_fu_ds  output  RW  forwarded i_write_reg.
REQ-018 o_valid, o_bus_err, o_misalign  output  1 each; o_write_reg  output  RW; o_write_data, o_result  output  DW; o_WB_control  output  WBW: MEM/WB register.

Function
REQ-019 o_branch = i_valid & i_branch & i_zero; o_branch_pc = i_branch_pc; to_exmux, to_fu_ds pass inputs through; all combinational.
REQ-020 FSM states IDLE, BUSY; a memory op is i_valid & (i_mem_read | i_mem_write); read and write both set is treated as write.
REQ-021 In IDLE, a memory op latches address, be, we and wdata into request registers and moves to BUSY; o_dm_req is registered and is high only in BUSY.
REQ-022 In BUSY, request outputs hold stable until i_dm_ack; on ack, return to IDLE and load the MEM/WB register the same edge.
REQ-023 o_stall = (IDLE & memory op) | (BUSY & ~i_dm_ack); the minimum memory-op latency is 2 cycles; a non-memory op never stalls.
REQ-024 The MEM/WB register loads when o_stall is low; while stalled it loads a bubble (o_valid=0, o_WB_control=0).
REQ-025 Store: o_dm_be is the size mask shifted by the byte offset addr[log2(DW/8)-1:0]; data is replicated into every lane.
REQ-026 Load: select the addressed lanes from i_dm_rdata, then sign-extend or, when i_unsigned=1, zero-extend to DW into o_write_data; store ops write o_write_data=0.
REQ-027 A 16-bit wait counter clears on entry to BUSY; if the count reaches TMO without ack: abort to IDLE, drop o_stall, load MEM/WB with o_WB_control=0, o_write_data=0, and pulse o_bus_err for 1 cycle.
REQ-028 An ack arriving in the same cycle the count reaches TMO is accepted, with no error.
REQ-029 i_dm_ack while in IDLE is ignored.

Reset
REQ-030 Asserting i_rst_n low forces IDLE, clears the counter and request registers, and deasserts o_dm_req immediately, abandoning any access in BUSY.
REQ-031 All registered outputs reset to 0; the first access after release starts from IDLE.

Configuration
REQ-032 Macro MEM_MISALIGN_TRAP_EN defined: a memory op whose address is not size-aligned issues no bus request and no stall; MEM/WB loads with o_WB_control=0, o_misalign=1 for 1 cycle.
REQ-033 Macro undefined: address bits below the size alignment are forced to 0 for lane selection and o_dm_addr; o_misalign is tied 0.

Verification
REQ-034 Word store: addr 0x10, data 0xA1B2C3D4, ack on 2nd BUSY cycle -> be=1111, o_stall high 2 cycles, bubble then o_valid=1.
REQ-035 Byte load: addr 0x13, rdata 0x80FF_FF7F, i_unsigned=0 -> o_write_data 0xFFFFFF80; repeat with i_unsigned=1 -> 0x00000080.
REQ-036 Half store: addr 0x22, data 0x0000BEEF -> be=1100, wdata 0xBEEFBEEF.
REQ-037 TMO=4, no ack -> o_bus_err pulses after the 4th BUSY cycle, o_WB_control=0, stall releases; ack at count 4 -> accepted, no error.
REQ-038 Reset asserted mid-BUSY -> o_dm_req low asynchronously, all outputs 0; with MEM_MISALIGN_TRAP_EN, a word load at 0x02 -> no o_dm_req, o_misalign=1.
